// File: rtl/wb_stage_pkg.sv
// Shared constants for the write-back stage: mem_op bit positions,
// exception codes and the default trace reset PC.
package wb_stage_pkg;

    localparam int OP_LB  = 0;
    localparam int OP_LH  = 1;
    localparam int OP_LW  = 2;
    localparam int OP_LBU = 3;
    localparam int OP_LHU = 4;
    localparam int OP_SB  = 5;
    localparam int OP_SH  = 6;
    localparam int OP_SW  = 7;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADE  = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0b;
    localparam logic [5:0] ECODE_BRK  = 6'h0c;
    localparam logic [5:0] ECODE_INE  = 6'h0d;

    localparam logic [31:0] RESET_PC_DEF = 32'h1c000000;

endpackage

// File: rtl/wb_stage_if.sv
// MEM->WB bundle: valid/ready handshake plus the registered memory
// stage fields. master = memory stage, slave = write-back stage.
interface wb_stage_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc;
    logic [7:0]  mem_op;
    logic [31:0] alu_result;
    logic [31:0] csr_result;
    logic [31:0] mul_result;
    logic [31:0] div_result;
    logic        res_from_mem;
    logic        res_from_csr;
    logic        res_from_mul;
    logic        res_from_div;
    logic        gr_we;
    logic [4:0]  dest;
    logic        has_exception;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic [31:0] exception_maddr;
    logic        ertn;
    logic        rdcntid;

    modport master (
        output in_valid, pc, mem_op,
        output alu_result, csr_result,
        output mul_result, div_result,
        output res_from_mem, res_from_csr,
        output res_from_mul, res_from_div,
        output gr_we, dest,
        output has_exception, ecode, esubcode,
        output exception_maddr, ertn, rdcntid,
        input  in_ready
    );

    modport slave (
        input  in_valid, pc, mem_op,
        input  alu_result, csr_result,
        input  mul_result, div_result,
        input  res_from_mem, res_from_csr,
        input  res_from_mul, res_from_div,
        input  gr_we, dest,
        input  has_exception, ecode, esubcode,
        input  exception_maddr, ertn, rdcntid,
        output in_ready
    );

endinterface

// File: rtl/wb_load_align.sv
// Load data extract/extend. Ports: rdata (SRAM word), offset (addr[1:0]),
// mem_op (load one-hot LB/LH/LW/LBU/LHU) -> ld_data (0 if no load bit).
module wb_load_align
    import wb_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [4:0]  mem_op,
    output logic [31:0] ld_data
);

    logic [31:0] byte_v;
    logic [31:0] half_v;

    assign byte_v = rdata >> {offset, 3'b000};
    // Halfwords are aligned: offset[0] is ignored.
    assign half_v = rdata >> {offset[1], 4'b0000};

    always_comb begin
        ld_data = '0;
        unique case (1'b1)
            mem_op[OP_LB]:  ld_data = {{24{byte_v[7]}}, byte_v[7:0]};
            mem_op[OP_LH]:  ld_data = {{16{half_v[15]}}, half_v[15:0]};
            mem_op[OP_LW]:  ld_data = rdata;
            mem_op[OP_LBU]: ld_data = {24'b0, byte_v[7:0]};
            mem_op[OP_LHU]: ld_data = {16'b0, half_v[15:0]};
            default:        ld_data = '0;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: load align, result select, GPR write, exception/ERTN
// commit, registered debug trace. Ports: clk, rst (sync, active-high),
// mem_wb (wb_stage_if.slave), data_sram_rdata, csr_tid, rf_*, ex_flush,
// ertn_flush, csr_ex_*, debug_wb_*. Optional WB_PERF_CNT_EN adds
// retire_cnt (64b) and excp_cnt (32b).
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    wb_stage_if.slave   mem_wb,
    input  logic [31:0] data_sram_rdata,
    input  logic [31:0] csr_tid,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        ex_flush,
    output logic        ertn_flush,
    output logic [31:0] csr_ex_pc,
    output logic [31:0] csr_ex_vaddr,
    output logic [5:0]  csr_ex_ecode,
    output logic [8:0]  csr_ex_esubcode,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_we,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
`ifdef WB_PERF_CNT_EN
    ,
    output logic [63:0] retire_cnt,
    output logic [31:0] excp_cnt
`endif
);

    logic [31:0] ld_data;
    logic        unused_store_ops;

    // Store bits carry no WB work.
    assign unused_store_ops = ^mem_wb.mem_op[7:5];

    // No stall source in WB.
    assign mem_wb.in_ready = ~rst;

    wb_load_align u_align (
        .rdata   (data_sram_rdata),
        .offset  (mem_wb.alu_result[1:0]),
        .mem_op  (mem_wb.mem_op[4:0]),
        .ld_data (ld_data)
    );

    always_comb begin
        rf_wdata = mem_wb.alu_result;
        if (mem_wb.rdcntid)
            rf_wdata = csr_tid;
        else if (mem_wb.res_from_mem)
            rf_wdata = ld_data;
        else if (mem_wb.res_from_csr)
            rf_wdata = mem_wb.csr_result;
        else if (mem_wb.res_from_mul)
            rf_wdata = mem_wb.mul_result;
        else if (mem_wb.res_from_div)
            rf_wdata = mem_wb.div_result;
    end

    assign rf_we = mem_wb.in_valid & mem_wb.gr_we
                 & ~mem_wb.has_exception & ~mem_wb.ertn;
    assign rf_waddr = mem_wb.dest;

    // Exception wins over ERTN.
    assign ex_flush   = mem_wb.in_valid & mem_wb.has_exception;
    assign ertn_flush = mem_wb.in_valid & mem_wb.ertn
                      & ~mem_wb.has_exception;

    assign csr_ex_pc       = mem_wb.pc;
    assign csr_ex_vaddr    = mem_wb.exception_maddr;
    assign csr_ex_ecode    = mem_wb.ecode;
    assign csr_ex_esubcode = mem_wb.esubcode;

    always_ff @(posedge clk) begin
        if (rst) begin
            debug_wb_pc       <= RESET_PC;
            debug_wb_rf_we    <= '0;
            debug_wb_rf_wnum  <= '0;
            debug_wb_rf_wdata <= '0;
        end else begin
            debug_wb_rf_we    <= {4{rf_we}};
            debug_wb_rf_wnum  <= rf_waddr;
            debug_wb_rf_wdata <= rf_wdata;
            if (mem_wb.in_valid)
                debug_wb_pc <= mem_wb.pc;
        end
    end

`ifdef WB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt <= '0;
            excp_cnt   <= '0;
        end else begin
            if (mem_wb.in_valid & ~mem_wb.has_exception)
                retire_cnt <= retire_cnt + 64'd1;
            if (ex_flush)
                excp_cnt <= excp_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed vectors push expectations,
// a negedge monitor pops and compares combinational and trace outputs.
module tb_wb_stage;
    import wb_stage_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] data_sram_rdata;
    logic [31:0] csr_tid;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        ex_flush;
    logic        ertn_flush;
    logic [31:0] csr_ex_pc;
    logic [31:0] csr_ex_vaddr;
    logic [5:0]  csr_ex_ecode;
    logic [8:0]  csr_ex_esubcode;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
`ifdef WB_PERF_CNT_EN
    logic [63:0] retire_cnt;
    logic [31:0] excp_cnt;
`endif

    wb_stage_if bus ();

    wb_stage #(.RESET_PC(32'h1c000000)) dut (
        .clk               (clk),
        .rst               (rst),
        .mem_wb            (bus.slave),
        .data_sram_rdata   (data_sram_rdata),
        .csr_tid           (csr_tid),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .ex_flush          (ex_flush),
        .ertn_flush        (ertn_flush),
        .csr_ex_pc         (csr_ex_pc),
        .csr_ex_vaddr      (csr_ex_vaddr),
        .csr_ex_ecode      (csr_ex_ecode),
        .csr_ex_esubcode   (csr_ex_esubcode),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
`ifdef WB_PERF_CNT_EN
        ,
        .retire_cnt        (retire_cnt),
        .excp_cnt          (excp_cnt)
`endif
    );

    typedef struct {
        string       nm;
        logic [31:0] pc;
        logic [7:0]  op;
        logic [31:0] alu, csr, mul, div;
        logic        fm, fc, fmul, fdiv;
        logic        gwe;
        logic [4:0]  dst;
        logic        exc;
        logic [5:0]  ec;
        logic [8:0]  esc;
        logic [31:0] badv;
        logic        er, rdc;
        logic [31:0] rdata, tid;
        logic        e_we;
        logic [31:0] e_wd;
        logic        e_ex, e_er;
    } vec_t;

    vec_t q[$];
    int checks = 0;
    int errors = 0;
    int m_ret = 0;
    int m_exc = 0;

    // Trace expectation kept by the monitor.
    logic        tr_ok = 0;
    logic        tr_full = 0;
    logic        tr_we = 0;
    logic [31:0] tr_pc = '0;
    logic [4:0]  tr_wn = '0;
    logic [31:0] tr_wd = '0;

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [63:0] act,
                                logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            tr_ok   = 1;
            tr_full = 1;
            tr_we   = 0;
            tr_pc   = 32'h1c000000;
            tr_wn   = '0;
            tr_wd   = '0;
        end else begin
            if (tr_ok) begin
                chk("trace_we", debug_wb_rf_we, {4{tr_we}});
                chk("trace_pc", debug_wb_pc, tr_pc);
                if (tr_full) begin
                    chk("trace_wnum", debug_wb_rf_wnum, tr_wn);
                    chk("trace_wdata", debug_wb_rf_wdata, tr_wd);
                end
            end
            if (bus.in_valid) begin
                if (q.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    vec_t e;
                    e = q.pop_front();
                    chk({e.nm, "_we"}, rf_we, e.e_we);
                    chk({e.nm, "_waddr"}, rf_waddr, e.dst);
                    chk({e.nm, "_wdata"}, rf_wdata, e.e_wd);
                    chk({e.nm, "_exf"}, ex_flush, e.e_ex);
                    chk({e.nm, "_ertnf"}, ertn_flush, e.e_er);
                    if (e.e_ex) begin
                        chk({e.nm, "_ecode"}, csr_ex_ecode, e.ec);
                        chk({e.nm, "_esub"}, csr_ex_esubcode, e.esc);
                        chk({e.nm, "_expc"}, csr_ex_pc, e.pc);
                        chk({e.nm, "_badv"}, csr_ex_vaddr, e.badv);
                    end
                    tr_we   = e.e_we;
                    tr_pc   = e.pc;
                    tr_wn   = e.dst;
                    tr_wd   = e.e_wd;
                    tr_full = 1;
                    tr_ok   = 1;
                end
            end else begin
                tr_we   = 0;
                tr_full = 0;
            end
        end
    end

    function automatic vec_t base(string nm, logic [31:0] pc);
        vec_t v;
        v.nm = nm; v.pc = pc; v.op = '0;
        v.alu = '0; v.csr = '0; v.mul = '0; v.div = '0;
        v.fm = 0; v.fc = 0; v.fmul = 0; v.fdiv = 0;
        v.gwe = 1; v.dst = 5'd5;
        v.exc = 0; v.ec = '0; v.esc = '0; v.badv = '0;
        v.er = 0; v.rdc = 0; v.rdata = '0; v.tid = '0;
        v.e_we = 1; v.e_wd = '0; v.e_ex = 0; v.e_er = 0;
        return v;
    endfunction

    task automatic drive(vec_t v);
        bus.pc              = v.pc;
        bus.mem_op          = v.op;
        bus.alu_result      = v.alu;
        bus.csr_result      = v.csr;
        bus.mul_result      = v.mul;
        bus.div_result      = v.div;
        bus.res_from_mem    = v.fm;
        bus.res_from_csr    = v.fc;
        bus.res_from_mul    = v.fmul;
        bus.res_from_div    = v.fdiv;
        bus.gr_we           = v.gwe;
        bus.dest            = v.dst;
        bus.has_exception   = v.exc;
        bus.ecode           = v.ec;
        bus.esubcode        = v.esc;
        bus.exception_maddr = v.badv;
        bus.ertn            = v.er;
        bus.rdcntid         = v.rdc;
        data_sram_rdata     = v.rdata;
        csr_tid             = v.tid;
        bus.in_valid        = 1;
    endtask

    task automatic issue(vec_t v);
        drive(v);
        q.push_back(v);
        if (v.exc) m_exc++;
        else m_ret++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        bus.in_valid = 0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        rst = 1;
        v = base("init", 32'h0);
        drive(v);
        bus.in_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_pc", debug_wb_pc, 32'h1c000000);
        chk("rst_we", debug_wb_rf_we, 0);
        chk("rst_wnum", debug_wb_rf_wnum, 0);
        chk("rst_wdata", debug_wb_rf_wdata, 0);
        rst = 0;
        #1;
        chk("run_in_ready", bus.in_ready, 1);
        idle(2);

        v = base("lb3", 32'h1c000100); v.op = 8'h01; v.fm = 1;
        v.alu = 32'h1c080003; v.rdata = 32'h80FF7F01;
        v.e_wd = 32'hFFFFFF80; issue(v);
        v.nm = "lbu3"; v.pc = 32'h1c000104; v.op = 8'h08;
        v.e_wd = 32'h00000080; issue(v);
        v.nm = "lb0"; v.pc = 32'h1c000108; v.op = 8'h01;
        v.alu = 32'h1c080000; v.e_wd = 32'h00000001; issue(v);
        v.nm = "lb1"; v.pc = 32'h1c00010c;
        v.alu = 32'h1c080001; v.e_wd = 32'h0000007F; issue(v);
        v.nm = "lb2"; v.pc = 32'h1c000110;
        v.alu = 32'h1c080002; v.e_wd = 32'hFFFFFFFF; issue(v);
        v.nm = "lbu2"; v.pc = 32'h1c000114; v.op = 8'h08;
        v.e_wd = 32'h000000FF; issue(v);
        idle(1);

        v = base("lh2", 32'h1c000120); v.op = 8'h02; v.fm = 1;
        v.alu = 32'h00000002; v.rdata = 32'h80017FFF;
        v.dst = 5'd9; v.e_wd = 32'hFFFF8001; issue(v);
        v.nm = "lhu2"; v.pc = 32'h1c000124; v.op = 8'h10;
        v.e_wd = 32'h00008001; issue(v);
        v.nm = "lh0"; v.pc = 32'h1c000128; v.op = 8'h02;
        v.alu = 32'h00000000; v.e_wd = 32'h00007FFF; issue(v);
        v.nm = "lh3"; v.pc = 32'h1c00012c;
        v.alu = 32'h00000003; v.e_wd = 32'hFFFF8001; issue(v);
        v.nm = "lhu1"; v.pc = 32'h1c000130; v.op = 8'h10;
        v.alu = 32'h00000001; v.e_wd = 32'h00007FFF; issue(v);
        v.nm = "lw"; v.pc = 32'h1c000134; v.op = 8'h04;
        v.alu = 32'h00000000; v.e_wd = 32'h80017FFF; issue(v);
        v.nm = "noload"; v.pc = 32'h1c000138; v.op = 8'h00;
        v.rdata = 32'hDEADBEEF; v.e_wd = 32'h0; issue(v);

        v = base("sw", 32'h1c000140); v.op = 8'h80; v.gwe = 0;
        v.alu = 32'h00000010; v.e_we = 0; v.e_wd = 32'h10; issue(v);
        v = base("add", 32'h1c000144); v.alu = 32'd5;
        v.dst = 5'd4; v.e_wd = 32'd5; issue(v);
        idle(2);

        v = base("memcsr", 32'h1c000150); v.op = 8'h04;
        v.fm = 1; v.fc = 1; v.csr = 32'h1111;
        v.rdata = 32'hCAFEF00D; v.e_wd = 32'hCAFEF00D; issue(v);
        v = base("csrmul", 32'h1c000154); v.fc = 1; v.fmul = 1;
        v.csr = 32'h2222; v.mul = 32'h3333; v.e_wd = 32'h2222;
        issue(v);
        v = base("muldiv", 32'h1c000158); v.fmul = 1; v.fdiv = 1;
        v.mul = 32'h3333; v.div = 32'h4444; v.e_wd = 32'h3333;
        issue(v);
        v = base("div", 32'h1c00015c); v.fdiv = 1;
        v.div = 32'h4444; v.e_wd = 32'h4444; issue(v);
        v = base("rdcnt", 32'h1c000160); v.rdc = 1; v.fc = 1;
        v.csr = 32'h9999; v.tid = 32'h1234; v.e_wd = 32'h1234;
        issue(v);
        v = base("rdcntmem", 32'h1c000164); v.rdc = 1; v.fm = 1;
        v.op = 8'h04; v.rdata = 32'h55AA55AA; v.tid = 32'hABCD;
        v.e_wd = 32'hABCD; issue(v);
        v = base("r0", 32'h1c000168); v.dst = 5'd0;
        v.alu = 32'h77; v.e_wd = 32'h77; issue(v);

        v = base("excp", 32'h1c000200); v.exc = 1; v.ec = ECODE_ADE;
        v.esc = 9'h001; v.badv = 32'h1001; v.alu = 32'h1001;
        v.dst = 5'd7; v.e_we = 0; v.e_wd = 32'h1001; v.e_ex = 1;
        issue(v);
        v = base("ertnexc", 32'h1c000204); v.exc = 1; v.er = 1;
        v.ec = ECODE_SYS; v.esc = 9'h0; v.badv = 32'h0;
        v.alu = 32'h42; v.e_we = 0; v.e_wd = 32'h42; v.e_ex = 1;
        issue(v);
        v = base("ertn", 32'h1c000208); v.er = 1; v.alu = 32'h9;
        v.e_we = 0; v.e_wd = 32'h9; v.e_er = 1; issue(v);
        idle(2);

        // Reset with an instruction in flight: not scoreboarded.
        v = base("add", 32'h1c000300); v.alu = 32'h123; v.dst = 5'd3;
        v.e_wd = 32'h123; issue(v);
        v = base("midrst", 32'h1c000304); v.alu = 32'h456;
        drive(v);
        rst = 1;
        m_ret = 0;
        m_exc = 0;
        @(posedge clk);
        #1;
        chk("mrst_in_ready", bus.in_ready, 0);
        chk("mrst_pc", debug_wb_pc, 32'h1c000000);
        chk("mrst_we", debug_wb_rf_we, 0);
        chk("mrst_wnum", debug_wb_rf_wnum, 0);
        chk("mrst_wdata", debug_wb_rf_wdata, 0);
`ifdef WB_PERF_CNT_EN
        chk("mrst_retire", retire_cnt, 0);
        chk("mrst_excp", excp_cnt, 32'h0);
`endif
        bus.in_valid = 0;
        @(posedge clk);
        #1;
        rst = 0;
        idle(1);

        for (int i = 0; i < 3; i++) begin
            v = base("cnt_add", 32'h1c000400 + 32'(4 * i));
            v.alu = 32'(i + 1); v.dst = 5'(i + 10);
            v.e_wd = 32'(i + 1); issue(v);
        end
        v = base("cnt_exc", 32'h1c00040c); v.exc = 1;
        v.ec = ECODE_INE; v.gwe = 1; v.alu = 32'h8;
        v.e_we = 0; v.e_wd = 32'h8; v.e_ex = 1; issue(v);
`ifdef WB_PERF_CNT_EN
        chk("retire_3", retire_cnt, 64'd3);
        chk("excp_1", excp_cnt, 32'd1);
`endif
        idle(2);
`ifdef WB_PERF_CNT_EN
        chk("retire_model", retire_cnt, 64'(m_ret));
        chk("excp_model", excp_cnt, 32'(m_exc));
`endif

        for (int i = 0; i < 20 && q.size() != 0; i++)
            @(posedge clk);
        if (q.size() != 0)
            chk("sb_drain", q.size(), 0);
        idle(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the five-stage LoongArch pipeline. It sits directly downstream of the memory stage and consumes that stage's registered outputs and the data SRAM read data. It aligns and extends load data, selects the final result, and drives the register-file write port. It commits exceptions and ERTN by raising the pipeline-wide flush, and produces a registered debug trace.

## Interface
Parameters:
- RESET_PC, 32'h1c000000, reset value of the trace PC.

Ports:
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- in_valid  in  1  memory stage holds a valid instruction
- in_ready  out  1  WB accepts; `~rst`
- pc  in  32  instruction PC
- mem_op  in  8  [0]LB [1]LH [2]LW [3]LBU [4]LHU [5]SB [6]SH [7]SW
- alu_result, csr_result, mul_result, div_result  in  32 each  candidate results; alu_result[1:0] is the load byte offset
- res_from_mem, res_from_csr, res_from_mul, res_from_div  in  1 each  result select
- gr_we  in  1  instruction writes GPR
- dest  in  5  destination GPR
- has_exception  in  1  exception flagged upstream
- ecode  in  6  exception code
- esubcode  in  9  exception subcode
- exception_maddr  in  32  bad virtual address
- ertn  in  1  instruction is ERTN
- rdcntid  in  1  instruction is RDCNTID
- data_sram_rdata  in  32  SRAM read data, valid in the cycle the load is in WB
- csr_tid  in  32  current TID CSR value
- rf_we  out  1  GPR write enable
- rf_waddr  out  5  GPR write address
- rf_wdata  out  32  GPR write data; also the WB bypass value
- ex_flush  out  1  exception commit, combinational
- ertn_flush  out  1  ERTN commit, combinational
- csr_ex_pc, csr_ex_vaddr  out  32 each  to CSR ERA/BADV
- csr_ex_ecode  out  6  to CSR ESTAT
- csr_ex_esubcode  out  9  to CSR ESTAT
- debug_wb_pc  out  32  registered trace PC
- debug_wb_rf_we  out  4  registered trace write strobe
- debug_wb_rf_wnum  out  5  registered trace write register
- debug_wb_rf_wdata  out  32  registered trace write data

## Operation
- WB has no stall source. ready_go is 1 and in_ready is `~rst`.
- Load extract:
  - byte = rdata >> (8*alu_result[1:0])
  - half = rdata >> (16*alu_result[1]); alu_result[0] is ignored for halfwords
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - If no load bit is set and res_from_mem=1, the load data is 0.
- Result priority: rdcntid → csr_tid, then mem, csr, mul, div, otherwise alu_result.
- rf_we = in_valid & gr_we & ~has_exception & ~ertn; rf_waddr = dest; rf_wdata = the selected result.
- ex_flush = in_valid & has_exception.
- ertn_flush = in_valid & ertn & ~has_exception. An exception takes precedence over ERTN.
- CSR exception outputs mirror pc, exception_maddr, ecode and esubcode. They are don't-care when ex_flush=0.

## Timing
- rf_*, ex_flush and ertn_flush are combinational in the same cycle as in_valid. The register file writes at that clock edge.
- Trace registers update every cycle from the current rf_we, rf_waddr, rf_wdata and pc, with debug_wb_rf_we = {4{rf_we}}. They therefore lag by one cycle.
- Trace PC updates only when in_valid=1; otherwise it holds.
- Reset values:
  - debug_wb_pc = RESET_PC
  - debug_wb_rf_we = 0
  - debug_wb_rf_wnum = 0
  - debug_wb_rf_wdata = 0
  - all counters = 0
- Writes to dest 0 are issued as presented; the register file ignores r0.
- If rst is asserted mid-flight, the trace is cleared the next edge and in_ready is 0 during rst.

## Configuration
- WB_PERF_CNT_EN defined:
  - Adds output retire_cnt (64 bit), incremented on every in_valid & ~has_exception.
  - Adds output excp_cnt (32 bit), incremented on every ex_flush. It wraps at 2^32 with no saturation.
  - Both counters reset to 0 on rst.
- WB_PERF_CNT_EN undefined: neither port nor counter exists.

## Structure
- Shared package holds:
  - mem_op bit indices
  - ECODE constants
  - RESET_PC default
- One sub-module, wb_load_align: combinational extract and extend from (rdata, offset, mem_op[4:0]).

## Test plan
- LB with rdata=32'h80FF7F01, offset 3 → rf_wdata=32'hFFFFFF80; LBU at offset 3 → 32'h00000080.
- LH with rdata=32'h8001_7FFF, offset 2 → 32'hFFFF8001; LHU at offset 2 → 32'h00008001.
- ADD with alu_result=5, gr_we=1, dest=4 → rf_we=1, rf_wdata=5; next cycle debug_wb_rf_we=4'hF, debug_wb_rf_wnum=4.
- has_exception=1, ecode=6'h08, gr_we=1 → rf_we=0, ex_flush=1, csr_ex_ecode=6'h08.
- ertn=1 and has_exception=1 together → ex_flush=1, ertn_flush=0.
- rdcntid=1 with csr_tid=32'h1234 and res_from_csr=1 → rf_wdata=32'h1234.
- With WB_PERF_CNT_EN: 3 valid instructions then 1 exception → retire_cnt=3, excp_cnt=1.
